// File: rtl/mul_red_arbiter.sv
// rtl/mul_red_arbiter.sv - round-robin arbiter/sequencer sharing one Curve448 modular multiplier
//
// Purpose: grants one of NREQ requesters at a time and drives the shared multiplier.
//   It latches the winner's operands, enables the multiplier, and captures the reduced product.
//   The result is returned with a one-cycle done pulse to the granted requester.
//   A watchdog flags err if mul_ready never arrives.
// Optional build macro: MUL_RECHECK_EN
//   When defined, the product is recomputed with swapped operands and compared;
//   a mismatch raises err.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   req[NREQ]         request levels
//   req_x/req_y       packed operands, requester i at [i*W +: W]
//   gnt/done[NREQ]    one-hot one-cycle pulses: operands latched / result valid
//   result[W], err    product (held until next done), error pulse with done
//   mul_x/mul_y       registered multiplier operands
//   mul_enable        registered multiplier enable
//   mul_reset         multiplier reset (follows reset)
//   mul_ready         multiplier ready
//   mul_result        multiplier product
module mul_red_arbiter #(
  parameter int NREQ    = 2,
  parameter int W       = 448,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic [W-1:0]    result,
  output logic            err,
  output logic [W-1:0]    mul_x,
  output logic [W-1:0]    mul_y,
  output logic            mul_enable,
  output logic            mul_reset,
  input  logic            mul_ready,
  input  logic [W-1:0]    mul_result
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_RUN2, S_RELEASE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr, cur, win;
  logic            any_req;
  logic [CW-1:0]   wd;
  logic            timed_out;

  logic [NREQ-1:0] gnt_d, done_d;
  logic            err_d, en_d;
  logic            ld_ops, swap_ops, cap_res, clr_res, wd_clr;

  assign mul_reset = reset;
  assign timed_out = (wd == CW'(TIMEOUT));

  // First set request at or after rr, wrapping. The loop walks downward so the
  // closest candidate to rr is the last one written.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(rr) + k) % NREQ]) begin
        any_req = 1'b1;
        win     = IW'((int'(rr) + k) % NREQ);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (any_req) state_nxt = S_RUN;
      S_RUN: begin
        if (mul_ready) begin
`ifdef MUL_RECHECK_EN
          state_nxt = S_GAP;
`else
          state_nxt = S_RELEASE;
`endif
        end else if (timed_out) begin
          state_nxt = S_RELEASE;
        end
      end
      S_GAP:     state_nxt = S_RUN2;
      S_RUN2:    if (mul_ready || timed_out) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    gnt_d    = '0;
    done_d   = '0;
    err_d    = 1'b0;
    en_d     = 1'b0;
    ld_ops   = 1'b0;
    swap_ops = 1'b0;
    cap_res  = 1'b0;
    clr_res  = 1'b0;
    wd_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        wd_clr = 1'b1;
        if (any_req) begin
          gnt_d  = NREQ'(1) << win;
          ld_ops = 1'b1;
          en_d   = 1'b1;
        end
      end
      S_RUN: begin
        en_d = 1'b1;
        if (mul_ready) begin
          cap_res = 1'b1;
          en_d    = 1'b0;
`ifdef MUL_RECHECK_EN
          swap_ops = 1'b1;
`else
          done_d   = NREQ'(1) << cur;
`endif
        end else if (timed_out) begin
          clr_res = 1'b1;
          en_d    = 1'b0;
          done_d  = NREQ'(1) << cur;
          err_d   = 1'b1;
        end
      end
      S_GAP: begin
        // Enable was low for one cycle so the multiplier has cleared; restart it.
        en_d   = 1'b1;
        wd_clr = 1'b1;
      end
      S_RUN2: begin
        en_d = 1'b1;
        if (mul_ready) begin
          // result still holds the first product; it is kept either way
          en_d   = 1'b0;
          done_d = NREQ'(1) << cur;
          err_d  = (mul_result != result);
        end else if (timed_out) begin
          clr_res = 1'b1;
          en_d    = 1'b0;
          done_d  = NREQ'(1) << cur;
          err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt        <= '0;
      done       <= '0;
      err        <= 1'b0;
      mul_enable <= 1'b0;
      result     <= '0;
      mul_x      <= '0;
      mul_y      <= '0;
      rr         <= '0;
      cur        <= '0;
      wd         <= '0;
    end else begin
      gnt        <= gnt_d;
      done       <= done_d;
      err        <= err_d;
      mul_enable <= en_d;
      if (ld_ops) begin
        mul_x <= req_x[int'(win)*W +: W];
        mul_y <= req_y[int'(win)*W +: W];
        cur   <= win;
        rr    <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
      end else if (swap_ops) begin
        mul_x <= mul_y;
        mul_y <= mul_x;
      end
      if (cap_res)      result <= mul_result;
      else if (clr_res) result <= '0;
      if (wd_clr)                             wd <= '0;
      else if (state == S_RUN || state == S_RUN2) wd <= wd + 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_red_arbiter.sv
// tb/tb_mul_red_arbiter.sv - directed self-checking bench for mul_red_arbiter
module tb_mul_red_arbiter;
  localparam int NREQ    = 2;
  localparam int W       = 448;
  localparam int TIMEOUT = 15;
`ifdef MUL_RECHECK_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 5;
`endif
  localparam logic [W-1:0] P = ~({{(W-1){1'b0}}, 1'b1} << 224);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] req_x = '0;
  logic [NREQ*W-1:0] req_y = '0;
  logic [NREQ-1:0]   gnt, done;
  logic [W-1:0]      result, mul_x, mul_y, mul_result;
  logic              err, mul_enable, mul_reset, mul_ready;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic hang = 1'b0;
  logic fault = 1'b0;

  mul_red_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .gnt(gnt), .done(done), .result(result), .err(err),
    .mul_x(mul_x), .mul_y(mul_y), .mul_enable(mul_enable), .mul_reset(mul_reset),
    .mul_ready(mul_ready), .mul_result(mul_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: ready on the 4th enabled edge, cleared when enable is low.
  int   mcnt;
  logic rdy;
  logic [2*W-1:0] prod;
  logic [W-1:0]   model_res;
  assign prod      = {{W{1'b0}}, mul_x} * {{W{1'b0}}, mul_y};
  assign model_res = W'(prod % {{W{1'b0}}, P});
  assign mul_ready = rdy;
  assign mul_result = rdy ? (model_res ^ ((fault && mul_x == W'(3)) ? W'(1) : W'(0))) : '0;

  always @(posedge clk or posedge mul_reset) begin
    if (mul_reset) begin
      mcnt <= 0; rdy <= 1'b0;
    end else if (!mul_enable) begin
      mcnt <= 0; rdy <= 1'b0;
    end else begin
      mcnt <= mcnt + 1;
      if (mcnt == 3 && !hang) rdy <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input string tag, output int c);
    int k = 0;
    @(negedge clk);
    while (gnt == '0 && k < 30) begin @(negedge clk); k++; end
    chk({tag, "_gnt_seen"}, W'(gnt != '0), W'(1));
    c = cyc;
  endtask

  task automatic wait_done(input string tag, output int c);
    int k = 0;
    @(negedge clk);
    while (done == '0 && k < 40) begin @(negedge clk); k++; end
    chk({tag, "_done_seen"}, W'(done != '0), W'(1));
    c = cyc;
  endtask

  task automatic op(input int idx, input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic [W-1:0] exp_r, input logic exp_e, input int lat, input string tag);
    int g, d;
    req_x[idx*W +: W] = x;
    req_y[idx*W +: W] = y;
    req[idx] = 1'b1;
    wait_gnt(tag, g);
    chk({tag, "_gnt"}, W'(gnt), W'(32'd1 << idx));
    chk({tag, "_mulx"}, mul_x, x);
    req[idx] = 1'b0;
    wait_done(tag, d);
    chk({tag, "_lat"}, W'(d - g), W'(lat));
    chk({tag, "_done"}, W'(done), W'(32'd1 << idx));
    chk({tag, "_result"}, result, exp_r);
    chk({tag, "_err"}, W'(err), W'(exp_e));
  endtask

  initial begin
    int g1, g2, d;
    logic seen;
    logic [W-1:0] x447;
    x447 = '0;
    x447[447] = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_gnt", W'(gnt), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_err", W'(err), '0);
    chk("rst_en", W'(mul_enable), '0);
    chk("rst_result", result, '0);
    chk("rst_mulx", mul_x, '0);
    chk("rst_mulreset", W'(mul_reset), W'(1));
    reset = 1'b0;
    @(negedge clk);

    // Single op and reduction
    op(0, W'(2), W'(3), W'(6), 1'b0, LAT, "single");
    op(0, x447, W'(2), (W'(1) << 224) + W'(1), 1'b0, LAT, "red_2p447");
    op(0, P - W'(1), P - W'(1), W'(1), 1'b0, LAT, "red_pm1");

    // Contention after a fresh reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_x = {W'(11), W'(5)};
    req_y = {W'(13), W'(7)};
    req = 2'b11;
    wait_gnt("cont0", g1);
    chk("cont_gnt0", W'(gnt), W'(1));
    req[0] = 1'b0;
    wait_done("cont0", d);
    chk("cont_done0", W'(done), W'(1));
    chk("cont_res0", result, W'(35));
    wait_gnt("cont1", g2);
    chk("cont_gnt1", W'(gnt), W'(2));
    chk("cont_gap", W'(g2 - g1), W'(LAT + 2));
    req[1] = 1'b0;
    wait_done("cont1", d);
    chk("cont_done1", W'(done), W'(2));
    chk("cont_res1", result, W'(143));

    // Fairness: both requesters held active
    req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_gnt("fair", g1);
      chk("fair_gnt", W'(gnt), W'((i % 2 == 0) ? 1 : 2));
      wait_done("fair", d);
      chk("fair_res", result, (i % 2 == 0) ? W'(35) : W'(143));
      if (i == 5) req = '0;
    end

    // Timeout
    hang = 1'b1;
    op(1, W'(9), W'(9), W'(0), 1'b1, TIMEOUT + 1, "timeout");
    hang = 1'b0;
    @(negedge clk);
    chk("to_en_low", W'(mul_enable), '0);
    op(1, W'(9), W'(9), W'(81), 1'b0, LAT, "after_to");

    // Reset in the middle of RUN
    req_x[W-1:0] = W'(4);
    req_y[W-1:0] = W'(5);
    req[0] = 1'b1;
    wait_gnt("midrst", g1);
    req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_en", W'(mul_enable), '0);
    chk("midrst_mulreset", W'(mul_reset), W'(1));
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done != '0 || gnt != '0) seen = 1'b1;
    end
    chk("midrst_quiet", W'(seen), '0);
    op(0, W'(4), W'(5), W'(20), 1'b0, LAT, "post_rst");

`ifdef MUL_RECHECK_EN
    fault = 1'b1;
    op(0, W'(2), W'(3), W'(6), 1'b1, 11, "recheck_fault");
    fault = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mul_red_arbiter.md
Name: mul_red_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one Curve448 modular multiplier (field p = 2^448 - 2^224 - 1) between NREQ requesters, e.g. the ladder's X/Z update units.
- Latches the winning requester's operands and drives the multiplier's enable/reset.
- Captures the reduced product and returns it with a per-requester done pulse.
- Adds a timeout watchdog, and optionally a swapped-operand recompute, to support error detection.

Parameters:
- NREQ, 2, number of requesters (2..8).
- W, 448, operand/result width.
- TIMEOUT, 15, maximum RUN cycles to wait for mul_ready before flagging an error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- req_x  in  NREQ*W  operand X, requester i at bits [i*W +: W].
- req_y  in  NREQ*W  operand Y, same packing.
- gnt  out  NREQ  one-hot, one-cycle pulse: operands latched.
- done  out  NREQ  one-hot, one-cycle pulse: result valid.
- result  out  W  reduced product; held until the next done.
- err  out  1  one-cycle pulse coincident with done: timeout or mismatch.
- mul_x  out  W  multiplier operand X (registered).
- mul_y  out  W  multiplier operand Y (registered).
- mul_enable  out  1  multiplier enable (registered).
- mul_reset  out  1  multiplier reset; equals reset, combinational.
- mul_ready  in  1  multiplier ready. The multiplier asserts it on the 4th enabled edge and clears it when enable is low.
- mul_result  in  W  multiplier result, valid while mul_ready=1.

Behaviour:
- Reset (async) clears the following:
  - state=IDLE, rr pointer=0.
  - gnt, done, err, mul_enable = 0.
  - result, mul_x, mul_y = 0.
  - Watchdog counter = 0.
- Reset mid-operation aborts the operation: no done and no gnt are emitted for it.
- IDLE:
  - If any req bit is set, grant the first set bit searching from rr upward, wrapping modulo NREQ.
  - At the edge: latch mul_x/mul_y from the winner, set gnt[i]=1 for one cycle, set mul_enable=1, rr=(i+1) mod NREQ, go to RUN.
- RUN:
  - mul_enable=1; the watchdog counts cycles.
  - Nominal: cycle N = gnt cycle, mul_ready is seen in cycle N+4.
  - When mul_ready=1: capture mul_result into result, drop mul_enable, go to RELEASE.
  - If the watchdog reaches TIMEOUT without mul_ready: result=0, err=1, go to RELEASE.
- RELEASE (1 cycle):
  - done[i]=1 (err if flagged), mul_enable=0 so the multiplier clears.
  - Next state is IDLE.
  - Nominal timing: done in cycle N+5, next gnt earliest in cycle N+7.
- Handshake:
  - Requesters hold req, req_x and req_y stable until gnt.
  - Dropping req before gnt withdraws the request.
  - A req still high when the arbiter returns to IDLE counts as a new request.
  - req changes outside IDLE are ignored.
- Fairness: with all NREQ requesters continuously active, each one is granted exactly once per NREQ operations.
- Width rule: operands are passed unmodified. The arbiter assumes mul_result < p and does no arithmetic of its own.

Optional Feature:
- Macro: MUL_RECHECK_EN.
- Defined:
  - After the first capture, go to GAP (1 cycle, mul_enable=0).
  - Then RUN2 with mul_x/mul_y swapped and mul_enable=1, under its own watchdog.
  - On mul_ready, compare with the stored result. On mismatch, err=1 and result keeps the first value.
  - Then go to RELEASE.
  - Nominal timing: done in cycle N+11.
- Undefined: GAP and RUN2 are absent and err reports timeout only.

Test Plan:
- Single op: requester 0 sends X=2, Y=3, with a multiplier model giving ready 4 edges after enable. Required: gnt[0] in cycle N, done[0] in N+5, result=6, err=0.
- Reduction: X=2^447, Y=2. Required: result=2^224+1. Also X=Y=p-1. Required: result=1.
- Contention: req=2'b11 after reset. Required: gnt[0] first, then gnt[1] at the next IDLE. Each result is routed with the matching done bit.
- Fairness: both requesters continuously active for 6 ops. Required: grant order 0,1,0,1,0,1.
- Timeout: multiplier model never asserts mul_ready. Required: done[i]=1 and err=1 in gnt cycle + TIMEOUT + 1, result=0, arbiter back in IDLE.
- Reset mid-RUN: assert reset 2 cycles after gnt. Required: mul_enable=0 immediately, no done emitted, a fresh request afterwards completes normally. With MUL_RECHECK_EN, a fault model corrupting the second run gives err=1 and done in N+11.
